regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/regfile_mp.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and address type for the multi-ported register file.
// The helpers keep the write-hit test identical wherever it is used.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

    // A write or issue only counts when it targets a real (nonzero) register.
    function automatic logic addr_live(input logic en, input logic [AW_DEF-1:0] addr);
        return en && (addr != '0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: issue sets, write-back clears, flush clears all.
// Set beats clear on the same register; flush beats set; reset beats everything.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NWR   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NWR-1:0]               we_i,
    input  logic [NWR*$clog2(NREGS)-1:0] waddr_i,
    input  logic                         iss_valid_i,
    input  logic [$clog2(NREGS)-1:0]     iss_rd_i,
    input  logic                         flush_i,
    output logic [NREGS-1:0]             busy_o
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW-1:0]    clr_addr [NWR];
    logic [NWR-1:0]   clr_en;
    logic             set_en;

    for (genvar k = 0; k < NWR; k++) begin : g_clr
        assign clr_addr[k] = waddr_i[k*AW +: AW];
        assign clr_en[k]   = we_i[k] && (clr_addr[k] != '0);
    end

    assign set_en = iss_valid_i && (iss_rd_i != '0);

    always_comb begin
        busy_d = busy_q;
        for (int unsigned k = 0; k < NWR; k++) begin
            if (clr_en[k]) begin
                busy_d[clr_addr[k]] = 1'b0;
            end
        end
        // A freshly reserved producer overrides a retiring one.
        if (set_en) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with x0 hardwired to zero, highest-port write
// priority, same-cycle write-to-read bypass and a busy scoreboard per register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NWR-1:0]               we,
    input  logic [NWR*$clog2(NREGS)-1:0] waddr,
    input  logic [NWR*XLEN-1:0]          wdata,
    input  logic [NRD*$clog2(NREGS)-1:0] raddr,
    output logic [NRD*XLEN-1:0]          rdata,
    output logic [NRD-1:0]               rbusy,
    input  logic                         iss_valid,
    input  logic [$clog2(NREGS)-1:0]     iss_rd,
    input  logic                         flush
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [AW-1:0]    wa     [NWR];
    logic [XLEN-1:0]  wd     [NWR];
    logic [NWR-1:0]   wr_en;
    logic [NREGS-1:0] busy;

    for (genvar k = 0; k < NWR; k++) begin : g_wr
        assign wa[k]    = waddr[k*AW +: AW];
        assign wd[k]    = wdata[k*XLEN +: XLEN];
        assign wr_en[k] = we[k] && (wa[k] != '0);
    end

    // Ascending port order makes the highest-numbered writer win.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned k = 0; k < NWR; k++) begin
            if (wr_en[k]) begin
                regs_d[wa[k]] = wd[k];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk_i       (clk),
        .rst_i       (rst),
        .we_i        (we),
        .waddr_i     (waddr),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .flush_i     (flush),
        .busy_o      (busy)
    );

    // Per read port: stored value, overridden by the winning same-cycle write.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] val;
        logic            hit;

        assign ra = raddr[p*AW +: AW];

        always_comb begin
            val = regs_q[ra];
            hit = 1'b0;
            for (int unsigned k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wa[k] == ra)) begin
                    val = wd[k];
                    hit = 1'b1;
                end
            end
            if (ra == '0) begin
                val = '0;
            end
        end

        assign rdata[p*XLEN +: XLEN] = val;
        assign rbusy[p]              = (ra != '0) && !hit && busy[ra];
    end

endmodule
